tcs3200_emulator: RTL

TCS3200_EMULATOR -- requirements
Module: tcs3200_emulator

---
 rtl/tcs3200_emulator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tcs3200_emulator.sv
// TCS3200 colour-sensor emulator. It drives a 50% square wave whose half-period
// is the selected filter's register multiplied by the S0/S1 frequency scaling.
module tcs3200_emulator #(
  parameter logic [11:0] RED_HALF_DEF   = 12'd10,
  parameter logic [11:0] GREEN_HALF_DEF = 12'd20,
  parameter logic [11:0] BLUE_HALF_DEF  = 12'd30,
  parameter logic [11:0] CLEAR_HALF_DEF = 12'd5,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic [1:0]  filter,
  input  logic [1:0]  scale,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_sel,
  input  logic [11:0] cfg_half_period,
  output logic        cfg_ready,
  output logic        cs_out,
  output logic        active
);

  typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [11:0] half_q [4];
  logic [11:0] half_d [4];
  logic [1:0]  filt_q, scale_q;
  logic [7:0]  scnt_q, scnt_d;
  logic [17:0] pcnt_q, pcnt_d;
  logic        cs_q, cs_d;
  logic        ready_q, ready_d;
  logic        wr, chg;
  logic [17:0] half_ext, eff;

  assign wr       = cfg_valid && ready_q;
  // Live inputs compared with last edge's registered copies.
  assign chg      = (filter != filt_q) || (scale != scale_q);
  assign half_ext = {6'd0, half_q[filt_q]};

  // Multipliers x5 and x50 built from shifts; 18 bits holds 4095*50.
  always_comb begin
    case (scale_q)
      2'b11:   eff = half_ext;
      2'b10:   eff = (half_ext << 2) + half_ext;
      2'b01:   eff = (half_ext << 5) + (half_ext << 4) + (half_ext << 1);
      default: eff = '0;
    endcase
  end

  always_comb begin
    half_d  = half_q;
    ready_d = 1'b1;
    state_d = state_q;
    scnt_d  = scnt_q;
    pcnt_d  = pcnt_q;
    cs_d    = cs_q;

    if (wr) begin
      half_d[cfg_sel] = cfg_half_period;
      ready_d         = 1'b0;
    end

    if (chg) begin
      state_d = (scale == 2'b00) ? ST_OFF : ST_SETTLE;
      scnt_d  = '0;
      pcnt_d  = '0;
      cs_d    = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          scnt_d = '0;
          pcnt_d = '0;
          cs_d   = 1'b0;
          if (scale_q != 2'b00) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          pcnt_d = '0;
          cs_d   = 1'b0;
          if (scnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          // A write to the live channel restarts the phase but keeps the level.
          if (wr && (cfg_sel == filt_q)) begin
            pcnt_d = '0;
          end else if (eff == '0) begin
            pcnt_d = '0;
            cs_d   = 1'b0;
          end else if (pcnt_q == eff - 18'd1) begin
            pcnt_d = '0;
            cs_d   = ~cs_q;
          end else begin
            pcnt_d = pcnt_q + 18'd1;
          end
        end
        default: begin
          state_d = ST_OFF;
          scnt_d  = '0;
          pcnt_d  = '0;
          cs_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1MHz) begin
    filt_q  <= filter;
    scale_q <= scale;
    if (rst) begin
      half_q[0] <= RED_HALF_DEF;
      half_q[1] <= BLUE_HALF_DEF;
      half_q[2] <= CLEAR_HALF_DEF;
      half_q[3] <= GREEN_HALF_DEF;
      state_q   <= ST_OFF;
      scnt_q    <= '0;
      pcnt_q    <= '0;
      cs_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      half_q  <= half_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      pcnt_q  <= pcnt_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cs_out    = cs_q;
  assign active    = (state_q == ST_RUN);

endmodule
